// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA decrypt controller: walks the message one byte per 12-state pass,
// swapping S entries and XORing the keystream into the decrypted-message RAM.
module rc4_decrypt_fsm #(
  parameter int unsigned MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] q,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       wren,
  output logic [1:0] mem_sel,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, LD_SI, RD_SJ, LD_SJ, WR_SI, WR_SJ,
    RD_F, LD_F, RD_M, LD_M, WR_D, NEXT, DONE
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_S    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_ROM  = 2'b11;
  localparam logic [7:0] K_LAST   = 8'(MSG_LEN - 1);

  state_t     state;
  logic [7:0] i, j, si, sj, f, m, k;

  // Outputs are loaded together with the next state, so each output register
  // holds the decode of the state being entered; values that are loaded from q
  // in the same edge (j, sj, m) are used directly from q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      f       <= '0;
      m       <= '0;
      k       <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      mem_sel <= SEL_NONE;
      done    <= 1'b0;
    end else begin
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      mem_sel <= SEL_NONE;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            i       <= 8'd1;
            j       <= '0;
            k       <= '0;
            state   <= RD_SI;
            mem_sel <= SEL_S;
            address <= 8'd1;
          end
        end
        RD_SI: state <= LD_SI;
        LD_SI: begin
          si      <= q;
          j       <= j + q;
          state   <= RD_SJ;
          mem_sel <= SEL_S;
          address <= j + q;
        end
        RD_SJ: state <= LD_SJ;
        LD_SJ: begin
          sj      <= q;
          state   <= WR_SI;
          mem_sel <= SEL_S;
          address <= i;
          data    <= q;
          wren    <= 1'b1;
        end
        WR_SI: begin
          state   <= WR_SJ;
          mem_sel <= SEL_S;
          address <= j;
          data    <= si;
          wren    <= 1'b1;
        end
        WR_SJ: begin
          state   <= RD_F;
          mem_sel <= SEL_S;
          address <= si + sj;
        end
        RD_F: state <= LD_F;
        LD_F: begin
          f       <= q;
          state   <= RD_M;
          mem_sel <= SEL_ROM;
          address <= k;
        end
        RD_M: state <= LD_M;
        LD_M: begin
          m       <= q;
          state   <= WR_D;
          mem_sel <= SEL_D;
          address <= k;
          data    <= f ^ q;
          wren    <= 1'b1;
        end
        WR_D: state <= NEXT;
        NEXT: begin
          if (k == K_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            k       <= k + 8'd1;
            i       <= i + 8'd1;
            state   <= RD_SI;
            mem_sel <= SEL_S;
            address <= i + 8'd1;
          end
        end
        DONE: begin
          if (start) done  <= 1'b1;
          else       state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Bench for rc4_decrypt_fsm: behavioural S RAM / ROM / message RAM plus an
// RC4 reference model feeding a queue of expected message-RAM writes.
module tb_rc4_decrypt_fsm;

  localparam int unsigned MSG_LEN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] q;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren;
  logic [1:0] mem_sel;
  logic       done;

  rc4_decrypt_fsm #(.MSG_LEN(MSG_LEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .q       (q),
    .address (address),
    .data    (data),
    .wren    (wren),
    .mem_sel (mem_sel),
    .done    (done)
  );

  always #5 clk = ~clk;

  logic [7:0]  s_mem [256];
  logic [7:0]  rom   [MSG_LEN];
  logic [7:0]  d_mem [MSG_LEN];
  logic [15:0] exp_q [$];
  logic [15:0] s_log [$];
  int total = 0;
  int bad = 0;
  int wren_cnt = 0;
  int d_writes = 0;
  int proto_err = 0;

  // memory handler: registered read, data valid the cycle after the address
  always @(posedge clk) begin
    if (wren) begin
      if (mem_sel == 2'b01) s_mem[address] = data;
      if (mem_sel == 2'b10) d_mem[address[4:0]] = data;
    end
    case (mem_sel)
      2'b01:   q <= s_mem[address];
      2'b10:   q <= d_mem[address[4:0]];
      2'b11:   q <= rom[address[4:0]];
      default: q <= 8'h00;
    endcase
  end

  // output monitor and scoreboard pop
  always @(negedge clk) begin
    if (wren) wren_cnt++;
    if ((mem_sel == 2'b11 && wren) || (mem_sel == 2'b10 && !wren)) proto_err++;
    if (wren && mem_sel == 2'b01) s_log.push_back({address, data});
    if (wren && mem_sel == 2'b10) begin
      logic [15:0] e;
      d_writes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL d_write_unexpected: got addr=%02h data=%02h, expected no write", address, data);
      end else begin
        e = exp_q.pop_front();
        if ({address, data} !== e) begin
          bad++;
          $display("FAIL d_write: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                   address, data, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_expected();
    logic [7:0] s [256];
    logic [7:0] ii, jj, t, f;
    for (int unsigned x = 0; x < 256; x++) s[x] = s_mem[x];
    ii = 8'd0;
    jj = 8'd0;
    for (int unsigned kk = 0; kk < MSG_LEN; kk++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      f = s[8'(s[ii] + s[jj])];
      exp_q.push_back({8'(kk), f ^ rom[kk]});
    end
  endtask

  task automatic load_mems(input logic [7:0] rom_val);
    for (int unsigned x = 0; x < 256; x++) s_mem[x] = 8'(x);
    for (int unsigned x = 0; x < MSG_LEN; x++) begin
      rom[x] = rom_val;
      d_mem[x] = 8'h00;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({address, data, wren, mem_sel, done} !== 20'h0) begin
      bad++;
      $display("FAIL %s: got addr=%02h data=%02h wren=%b sel=%b done=%b, expected all 0",
               name, address, data, wren, mem_sel, done);
    end
  endtask

  // start at a negedge, hold it, count edges after the sampling edge until done
  task automatic run_until_done(output int n);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!done && n < 1000);
  endtask

  task automatic check_run_totals(input string name, input int w0, input int d0);
    total++;
    if (wren_cnt - w0 != 3 * MSG_LEN) begin
      bad++;
      $display("FAIL %s_wren_count: got %0d, expected %0d", name, wren_cnt - w0, 3 * MSG_LEN);
    end
    total++;
    if (d_writes - d0 != MSG_LEN || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_d_writes: got %0d left=%0d, expected %0d left=0",
               name, d_writes - d0, exp_q.size(), MSG_LEN);
    end
  endtask

  task automatic test_reset();
    int w0;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    w0 = wren_cnt;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle_outputs("reset_outputs");
    end
    total++;
    if (wren_cnt != w0) begin
      bad++;
      $display("FAIL reset_wren: got %0d pulses, expected 0", wren_cnt - w0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_identity_run();
    int n, w0, d0;
    load_mems(8'h00);
    push_expected();
    s_log.delete();
    w0 = wren_cnt;
    d0 = d_writes;
    run_until_done(n);
    total++;
    if (n != 12 * MSG_LEN) begin
      bad++;
      $display("FAIL done_latency: got %0d edges, expected %0d", n, 12 * MSG_LEN);
    end
    total++;
    if (d_mem[0] !== 8'h02 || d_mem[1] !== 8'h05) begin
      bad++;
      $display("FAIL identity_d01: got %02h %02h, expected 02 05", d_mem[0], d_mem[1]);
    end
    total++;
    if (s_log.size() < 4 || s_log[0] !== 16'h0101 || s_log[1] !== 16'h0101) begin
      bad++;
      $display("FAIL byte0_swap_same_addr: got %04h %04h, expected 0101 0101", s_log[0], s_log[1]);
    end
    total++;
    if (s_log[2] !== 16'h0203 || s_log[3] !== 16'h0302) begin
      bad++;
      $display("FAIL byte1_swap: got %04h %04h, expected 0203 0302", s_log[2], s_log[3]);
    end
    check_run_totals("identity", w0, d0);
    w0 = wren_cnt;
    for (int c = 0; c < 5; c++) @(negedge clk);
    total++;
    if (done !== 1'b1 || wren_cnt != w0) begin
      bad++;
      $display("FAIL done_hold: got done=%b pulses=%0d, expected done=1 pulses=0", done, wren_cnt - w0);
    end
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("done_release");
    for (int c = 0; c < 5; c++) @(negedge clk);
    total++;
    if (wren_cnt != w0 || mem_sel !== 2'b00) begin
      bad++;
      $display("FAIL no_second_run: got pulses=%0d sel=%b, expected 0 and 00", wren_cnt - w0, mem_sel);
    end
  endtask

  task automatic test_back_to_back();
    int n, w0, d0;
    for (int unsigned x = 0; x < MSG_LEN; x++) rom[x] = 8'(x * 7 + 3);
    push_expected();
    w0 = wren_cnt;
    d0 = d_writes;
    run_until_done(n);
    total++;
    if (n != 12 * MSG_LEN) begin
      bad++;
      $display("FAIL b2b_latency: got %0d edges, expected %0d", n, 12 * MSG_LEN);
    end
    check_run_totals("b2b", w0, d0);
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("b2b_release");
  endtask

  task automatic test_reset_midrun();
    int n, w0, d0, guard;
    load_mems(8'hFF);
    push_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d0 = d_writes;
    guard = 0;
    while (d_writes - d0 < 10 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (d_writes - d0 != 10) begin
      bad++;
      $display("FAIL midrun_progress: got %0d writes, expected 10", d_writes - d0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrun_reset");
    total++;
    if (exp_q.size() != MSG_LEN - 10) begin
      bad++;
      $display("FAIL midrun_pending: got %0d, expected %0d", exp_q.size(), MSG_LEN - 10);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrun_idle");
    load_mems(8'hFF);
    push_expected();
    w0 = wren_cnt;
    d0 = d_writes;
    run_until_done(n);
    total++;
    if (n != 12 * MSG_LEN || d_mem[0] !== 8'hFD || d_mem[1] !== 8'hFA) begin
      bad++;
      $display("FAIL restart_run: got n=%0d d0=%02h d1=%02h, expected n=%0d FD FA",
               n, d_mem[0], d_mem[1], 12 * MSG_LEN);
    end
    check_run_totals("restart", w0, d0);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (proto_err != 0) begin
      bad++;
      $display("FAIL mem_sel_protocol: got %0d violations, expected 0", proto_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_identity_run();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_fsm.md
RC4_DECRYPT_FSM -- requirements
Module: rc4_decrypt_fsm

Interface
REQ-001 Parameter: MSG_LEN, 32, message length in bytes (1..256); ROM/RAM addressed 0..MSG_LEN-1.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  level request from the top-level controller; run begins when sampled high in IDLE.
REQ-005 Port: q  in  8  read data from the memory handler's shared read path; valid in the cycle after the address was driven.
REQ-006 Port: address  out  8  memory address; message memories use bits [4:0] at MSG_LEN=32.
REQ-007 Port: data  out  8  write data.
REQ-008 Port: wren  out  1  write enable; high for exactly one cycle per write.
REQ-009 Port: mem_sel  out  2  target: 00 none, 01 working S RAM, 10 decrypted-message RAM, 11 encrypted-message ROM.
REQ-010 Port: done  out  1  run complete; held until start deasserts.

Function
REQ-011 Implements the RC4 PRGA on the 256-byte S array previously built by the init and shuffle stages; it initiates requests toward the memory handler.
REQ-012 Registers: i, j, si, sj, f, m (8 bit each, arithmetic mod 256); k (counter, 0..MSG_LEN-1).
REQ-013 States, in order per byte: RD_SI, LD_SI, RD_SJ, LD_SJ, WR_SI, WR_SJ, RD_F, LD_F, RD_M, LD_M, WR_D, NEXT; plus IDLE and DONE.
REQ-014 IDLE: start high -> i<=1, j<=0, k<=0, go RD_SI; else stay.
REQ-015 RD_SI: mem_sel=01, address=i, wren=0.  LD_SI: si<=q, j<=j+q.
REQ-016 RD_SJ: mem_sel=01, address=j (updated).  LD_SJ: sj<=q.
REQ-017 WR_SI: mem_sel=01, address=i, data=sj, wren=1.  WR_SJ: mem_sel=01, address=j, data=si, wren=1.
REQ-018 RD_F: mem_sel=01, address=si+sj.  LD_F: f<=q.
REQ-019 RD_M: mem_sel=11, address=k.  LD_M: m<=q.
REQ-020 WR_D: mem_sel=10, address=k, data=f XOR m, wren=1.
REQ-021 NEXT: k==MSG_LEN-1 -> DONE; else k<=k+1, i<=i+1, go RD_SI.
REQ-022 DONE: done=1; start low -> IDLE; start held high does not retrigger.
REQ-023 All states not listed as driving a memory output drive address=0, data=0, wren=0, mem_sel=00; outputs are decoded from registered state only.
REQ-024 i==j: both swap writes go to the same address in order; final S value is unchanged.
REQ-025 start deasserting during a run is ignored; the run completes.
REQ-026 Latency: done rises on edge 12*MSG_LEN after the edge that samples start (384 at MSG_LEN=32).
REQ-027 Index wraps mod 256 (i, j, si+sj) with no overflow flag.

Reset
REQ-028 reset high at any edge, including mid-run: next state IDLE, all registers 0, address=0, data=0, wren=0, mem_sel=00, done=0.
REQ-029 Partial writes from an interrupted run are not undone; a restart recomputes from the current S contents.

Verification
REQ-030 Reset held 3 cycles -> all outputs 0, done=0, no wren pulse.
REQ-031 S[x]=x, ROM all 0x00, start pulse -> d[0]=0x02 (i=j=1), d[1]=0x05, S[2]=0x03, S[3]=0x02 after byte 1.
REQ-032 Byte 0 of the same run -> WR_SI and WR_SJ both write address 1 with data 0x01 (i==j case).
REQ-033 Start held high -> done rises exactly 384 edges after the sampling edge, stays high; start dropped -> IDLE next edge, done=0; no second run.
REQ-034 ROM=0xFF pattern, reset asserted at k=10 -> wren=0 next cycle, state IDLE; with S reloaded to identity, restart gives d[k]=~(identity keystream) for all 32 bytes.
REQ-035 Every run -> exactly 3*MSG_LEN wren pulses; mem_sel=10 only in WR_D; mem_sel=11 never with wren=1.
